ppu_vram_arb: RTL and testbench

PPU_VRAM_ARB -- requirements
Module: ppu_vram_arb

---
 rtl/ppu_vram_arb.sv | 182 ++++++++++++++++++
 tb/tb_ppu_vram_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_vram_arb
//  Purpose  : Arbitrates PPU video-memory ports between the render engine and
//             CPU PPUDATA accesses. Render requests always win their port; a
//             CPU access waits until its target port is free. The module
//             keeps the PPUADDR register with +1/+32 auto-increment, and the
//             PPUDATA read buffer (palette reads bypass it).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk, i_rstn          clock, asynchronous active-low reset
//    i_inc32                address step select (1: +32, 0: +1)
//    i_addr_ld, i_addr      PPUADDR load strobe and value (14 bit)
//    i_cpu_req/we/wdata     one-cycle PPUDATA access strobe, direction, data
//    o_cpu_busy/ack/rdata   access in progress, completion pulse, read data
//    i_rde_*_req/_addr      render-engine port claims and addresses
//    o_nt_*, i_nt_rdata     nametable port   (12-bit address, read/write)
//    o_pt_addr, i_pt_rdata  pattern port     (12-bit address, 16-bit, read only)
//    o_plt_*, i_plt_rdata   palette port     (5-bit address, read/write)
// ============================================================================
module ppu_vram_arb (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_inc32,
   input  logic        i_addr_ld,
   input  logic [13:0] i_addr,
   input  logic        i_cpu_req,
   input  logic        i_cpu_we,
   input  logic [7:0]  i_cpu_wdata,
   output logic        o_cpu_busy,
   output logic        o_cpu_ack,
   output logic [7:0]  o_cpu_rdata,
   input  logic        i_rde_nt_req,
   input  logic        i_rde_pt_req,
   input  logic        i_rde_plt_req,
   input  logic [11:0] i_rde_nt_addr,
   input  logic [11:0] i_rde_pt_addr,
   input  logic [4:0]  i_rde_plt_addr,
   output logic [11:0] o_nt_addr,
   output logic        o_nt_we,
   output logic [7:0]  o_nt_wdata,
   input  logic [7:0]  i_nt_rdata,
   output logic [11:0] o_pt_addr,
   input  logic [15:0] i_pt_rdata,
   output logic [4:0]  o_plt_addr,
   output logic        o_plt_we,
   output logic [7:0]  o_plt_wdata,
   input  logic [7:0]  i_plt_rdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   localparam logic [1:0] T_PT     = 2'd0;
   localparam logic [1:0] T_NT     = 2'd1;
   localparam logic [1:0] T_PLT    = 2'd2;

   logic [1:0]  r_state;
   logic [13:0] r_vaddr;   // PPUADDR
   logic [13:0] r_a;       // address latched for the in-flight access
   logic        r_we;
   logic [7:0]  r_wdata;
   logic [7:0]  r_buf;     // PPUDATA read buffer
   logic [7:0]  r_rdata;

   logic [1:0]  w_tgt;
   logic        w_port_free;
   logic        w_grant;
   logic        w_nt_sel;
   logic [4:0]  w_plt_idx;
   logic [11:0] w_pt_idx;
   logic [7:0]  w_pt_byte;
   logic [13:0] w_step;

   // Target decode of the latched address
   always_comb begin
      w_tgt = T_NT;
      if (!r_a[13])
         w_tgt = T_PT;
      else if (r_a[13:8] == 6'h3F)
         w_tgt = T_PLT;
   end

   // Entries 0x10/0x14/0x18/0x1C mirror the backdrop entries 0x00/0x04/...
   assign w_plt_idx = (r_a[4] && (r_a[1:0] == 2'b00)) ? {1'b0, r_a[3:0]} : r_a[4:0];
   // Bit 3 selects the bitplane, so it is dropped from the word address
   assign w_pt_idx  = {r_a[12], r_a[11:4], r_a[2:0]};
   assign w_pt_byte = r_a[3] ? i_pt_rdata[15:8] : i_pt_rdata[7:0];

   // A palette read also fetches the nametable byte underneath it to refill
   // the read buffer, so it needs both ports in the same cycle.
   always_comb begin
      w_port_free = 1'b0;
      case (w_tgt)
         T_PT:    w_port_free = !i_rde_pt_req;
         T_NT:    w_port_free = !i_rde_nt_req;
         T_PLT:   w_port_free = r_we ? !i_rde_plt_req
                                     : (!i_rde_plt_req && !i_rde_nt_req);
         default: w_port_free = 1'b0;
      endcase
   end

   assign w_grant  = (r_state == S_WAIT) && w_port_free;
   assign w_nt_sel = w_grant && ((w_tgt == T_NT) || ((w_tgt == T_PLT) && !r_we));
   assign w_step   = i_inc32 ? 14'd32 : 14'd1;

   // Memory ports: the CPU only takes a port in its grant cycle, and a grant
   // is never given while the render engine claims that port.
   assign o_nt_addr   = w_nt_sel ? r_a[11:0] : i_rde_nt_addr;
   assign o_nt_we     = w_grant && (w_tgt == T_NT) && r_we;
   assign o_nt_wdata  = r_wdata;
   assign o_pt_addr   = (w_grant && (w_tgt == T_PT)) ? w_pt_idx : i_rde_pt_addr;
   assign o_plt_addr  = (w_grant && (w_tgt == T_PLT)) ? w_plt_idx : i_rde_plt_addr;
   assign o_plt_we    = w_grant && (w_tgt == T_PLT) && r_we;
   assign o_plt_wdata = r_wdata;

   assign o_cpu_busy  = (r_state != S_IDLE);
   assign o_cpu_ack   = (r_state == S_RESP);
   assign o_cpu_rdata = r_rdata;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= S_IDLE;
         r_vaddr <= 14'h0000;
         r_a     <= 14'h0000;
         r_we    <= 1'b0;
         r_wdata <= 8'h00;
         r_buf   <= 8'h00;
         r_rdata <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_cpu_req) begin
                  r_a     <= r_vaddr;
                  r_we    <= i_cpu_we;
                  r_wdata <= i_cpu_wdata;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_grant)
                  r_state <= S_ACCESS;
            end
            S_ACCESS: begin
               // Read data for the grant cycle's address is valid now
               if (!r_we) begin
                  case (w_tgt)
                     T_PT: begin
                        r_rdata <= r_buf;
                        r_buf   <= w_pt_byte;
                     end
                     T_NT: begin
                        r_rdata <= r_buf;
                        r_buf   <= i_nt_rdata;
                     end
                     default: begin
                        r_rdata <= i_plt_rdata;
                        r_buf   <= i_nt_rdata;
                     end
                  endcase
               end
               r_state <= S_RESP;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         // A load in the same cycle overrides the increment; the in-flight
         // access keeps its own copy in r_a.
         if (i_addr_ld)
            r_vaddr <= i_addr;
         else if (r_state == S_RESP)
            r_vaddr <= r_vaddr + w_step;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ppu_vram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ppu_vram_arb
//  Purpose  : Self-checking bench for ppu_vram_arb. Behavioural memories with
//             one-cycle read latency sit on the three ports; a reference model
//             predicts each CPU read result into a scoreboard queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ppu_vram_arb;

   logic        i_clk = 1'b0;
   logic        i_rstn = 1'b0;
   logic        i_inc32 = 1'b0;
   logic        i_addr_ld = 1'b0;
   logic [13:0] i_addr = 14'h0;
   logic        i_cpu_req = 1'b0;
   logic        i_cpu_we = 1'b0;
   logic [7:0]  i_cpu_wdata = 8'h0;
   logic        o_cpu_busy, o_cpu_ack;
   logic [7:0]  o_cpu_rdata;
   logic        i_rde_nt_req = 1'b0, i_rde_pt_req = 1'b0, i_rde_plt_req = 1'b0;
   logic [11:0] i_rde_nt_addr = 12'h0, i_rde_pt_addr = 12'h0;
   logic [4:0]  i_rde_plt_addr = 5'h0;
   logic [11:0] o_nt_addr, o_pt_addr;
   logic        o_nt_we, o_plt_we;
   logic [7:0]  o_nt_wdata, o_plt_wdata;
   logic [4:0]  o_plt_addr;
   logic [7:0]  i_nt_rdata = 8'h0, i_plt_rdata = 8'h0;
   logic [15:0] i_pt_rdata = 16'h0;

   ppu_vram_arb dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_inc32(i_inc32),
      .i_addr_ld(i_addr_ld), .i_addr(i_addr),
      .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_wdata(i_cpu_wdata),
      .o_cpu_busy(o_cpu_busy), .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata),
      .i_rde_nt_req(i_rde_nt_req), .i_rde_pt_req(i_rde_pt_req),
      .i_rde_plt_req(i_rde_plt_req),
      .i_rde_nt_addr(i_rde_nt_addr), .i_rde_pt_addr(i_rde_pt_addr),
      .i_rde_plt_addr(i_rde_plt_addr),
      .o_nt_addr(o_nt_addr), .o_nt_we(o_nt_we), .o_nt_wdata(o_nt_wdata),
      .i_nt_rdata(i_nt_rdata),
      .o_pt_addr(o_pt_addr), .i_pt_rdata(i_pt_rdata),
      .o_plt_addr(o_plt_addr), .o_plt_we(o_plt_we), .o_plt_wdata(o_plt_wdata),
      .i_plt_rdata(i_plt_rdata)
   );

   always #5 i_clk = ~i_clk;

   // Behavioural memories seen by the DUT
   logic [7:0]  nt_mem  [4096];
   logic [15:0] pt_mem  [4096];
   logic [7:0]  plt_mem [32];
   // Reference copies updated only by the model
   logic [7:0]  sh_nt   [4096];
   logic [15:0] sh_pt   [4096];
   logic [7:0]  sh_plt  [32];

   always @(posedge i_clk) begin
      i_nt_rdata  <= nt_mem[o_nt_addr];
      i_pt_rdata  <= pt_mem[o_pt_addr];
      i_plt_rdata <= plt_mem[o_plt_addr];
      if (o_nt_we)  nt_mem[o_nt_addr]   <= o_nt_wdata;
      if (o_plt_we) plt_mem[o_plt_addr] <= o_plt_wdata;
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model state
   logic [13:0] m_addr  = 14'h0;
   logic [7:0]  m_buf   = 8'h0;
   logic [7:0]  m_rdata = 8'h0;
   logic [7:0]  sb [$];

   task automatic model_issue(input bit we, input logic [7:0] wd);
      logic [13:0] a;
      logic [4:0]  pidx;
      logic [15:0] w;
      logic [7:0]  b;
      a    = m_addr;
      pidx = (a[4] && a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a[4:0];
      if (we) begin
         if (a >= 14'h3F00)      sh_plt[pidx] = wd;
         else if (a >= 14'h2000) sh_nt[a[11:0]] = wd;
         sb.push_back(m_rdata);
      end else if (a >= 14'h3F00) begin
         sb.push_back(sh_plt[pidx]);
         m_rdata = sh_plt[pidx];
         m_buf   = sh_nt[a[11:0]];
      end else begin
         if (a >= 14'h2000) b = sh_nt[a[11:0]];
         else begin
            w = sh_pt[{a[12], a[11:4], a[2:0]}];
            b = a[3] ? w[15:8] : w[7:0];
         end
         sb.push_back(m_buf);
         m_rdata = m_buf;
         m_buf   = b;
      end
   endtask

   task automatic load_addr(input logic [13:0] v);
      @(negedge i_clk);
      i_addr_ld = 1'b1;
      i_addr    = v;
      @(negedge i_clk);
      i_addr_ld = 1'b0;
      m_addr    = v;
   endtask

   // One CPU access; hold>0 keeps the nametable port claimed by the render
   // engine for that many WAIT cycles. ld loads ldv during the ack cycle.
   task automatic cpu_op(input bit we, input logic [7:0] wd, input int hold,
                         input bit ld, input logic [13:0] ldv);
      int cnt;
      int viol;
      logic [7:0] e;
      @(negedge i_clk);
      i_cpu_req   = 1'b1;
      i_cpu_we    = we;
      i_cpu_wdata = wd;
      if (hold > 0) begin
         i_rde_nt_req  = 1'b1;
         i_rde_nt_addr = 12'h7C3;
      end
      model_issue(we, wd);
      @(negedge i_clk);
      i_cpu_req = 1'b0;
      cnt  = 1;
      viol = 0;
      while (!o_cpu_ack && cnt < 200) begin
         if (i_rde_nt_req && (o_nt_we || !o_cpu_busy || o_nt_addr != 12'h7C3))
            viol++;
         if (cnt == hold + 1) i_rde_nt_req = 1'b0;
         @(negedge i_clk);
         cnt++;
      end
      i_rde_nt_req = 1'b0;
      chk("ack_latency", cnt, 3 + hold);
      if (hold > 0) chk("rde_priority_violations", viol, 0);
      if (o_cpu_ack && sb.size() > 0) begin
         e = sb.pop_front();
         chk("cpu_rdata", o_cpu_rdata, e);
      end
      if (ld) begin
         i_addr_ld = 1'b1;
         i_addr    = ldv;
         m_addr    = ldv;
      end else begin
         m_addr = m_addr + (i_inc32 ? 14'd32 : 14'd1);
      end
      @(negedge i_clk);
      i_addr_ld = 1'b0;
      chk("busy_after_ack", o_cpu_busy, 0);
   endtask

   initial begin
      int diffs;
      int viol;
      for (int i = 0; i < 4096; i++) begin
         nt_mem[i] = 8'(i) ^ 8'h5A;
         pt_mem[i] = {8'(i) ^ 8'hC3, 8'(i >> 4) + 8'h01};
      end
      for (int i = 0; i < 32; i++) plt_mem[i] = 8'h20 + 8'(i);
      nt_mem[0] = 8'h11;
      nt_mem[1] = 8'h22;
      for (int i = 0; i < 4096; i++) begin
         sh_nt[i] = nt_mem[i];
         sh_pt[i] = pt_mem[i];
      end
      for (int i = 0; i < 32; i++) sh_plt[i] = plt_mem[i];

      // Reset state
      repeat (3) @(negedge i_clk);
      chk("rst_busy", o_cpu_busy, 0);
      chk("rst_ack", o_cpu_ack, 0);
      chk("rst_rdata", o_cpu_rdata, 8'h00);
      chk("rst_we", {o_nt_we, o_plt_we}, 0);
      i_rstn = 1'b1;

      // Nametable write with auto-increment
      load_addr(14'h2005);
      cpu_op(1'b1, 8'hA5, 0, 1'b0, 14'h0);
      chk("nt_005", nt_mem[12'h005], 8'hA5);
      cpu_op(1'b1, 8'hB6, 0, 1'b0, 14'h0);
      chk("nt_006_after_inc", nt_mem[12'h006], 8'hB6);

      // Buffered nametable reads
      load_addr(14'h2000);
      repeat (4) cpu_op(1'b0, 8'h00, 0, 1'b0, 14'h0);

      // Palette mirror write, direct palette read
      load_addr(14'h3F10);
      cpu_op(1'b1, 8'h0F, 0, 1'b0, 14'h0);
      chk("plt_mirror_00", plt_mem[5'h00], 8'h0F);
      load_addr(14'h3F00);
      cpu_op(1'b0, 8'h00, 0, 1'b0, 14'h0);
      chk("plt_read_direct", o_cpu_rdata, 8'h0F);

      // Pattern write completes without a memory write; pattern reads, bit 3
      load_addr(14'h0123);
      cpu_op(1'b1, 8'h99, 0, 1'b0, 14'h0);
      load_addr(14'h0008);
      repeat (3) cpu_op(1'b0, 8'h00, 0, 1'b0, 14'h0);

      // Render engine holds the nametable port during a write
      load_addr(14'h2210);
      cpu_op(1'b1, 8'h5C, 10, 1'b0, 14'h0);
      chk("nt_210_after_stall", nt_mem[12'h210], 8'h5C);

      // +32 wrap; palette read blocked by nametable claim; load in ack cycle
      i_inc32 = 1'b1;
      load_addr(14'h3FF0);
      cpu_op(1'b0, 8'h00, 3, 1'b0, 14'h0);
      cpu_op(1'b0, 8'h00, 0, 1'b0, 14'h0);
      cpu_op(1'b0, 8'h00, 0, 1'b1, 14'h2100);
      cpu_op(1'b1, 8'h77, 0, 1'b0, 14'h0);
      chk("nt_100_load_wins", nt_mem[12'h100], 8'h77);
      i_inc32 = 1'b0;

      // Reset while a write waits for the nametable port
      load_addr(14'h2040);
      @(negedge i_clk);
      i_rde_nt_req  = 1'b1;
      i_rde_nt_addr = 12'h333;
      i_cpu_req     = 1'b1;
      i_cpu_we      = 1'b1;
      i_cpu_wdata   = 8'hEE;
      @(negedge i_clk);
      i_cpu_req = 1'b0;
      @(negedge i_clk);
      chk("wait_busy", o_cpu_busy, 1);
      i_rstn = 1'b0;
      #1;
      chk("rst_mid_busy", o_cpu_busy, 0);
      chk("rst_mid_ack", o_cpu_ack, 0);
      i_rde_nt_req = 1'b0;
      viol = 0;
      repeat (3) begin
         @(negedge i_clk);
         if (o_nt_we || o_plt_we) viol++;
      end
      chk("rst_mid_no_we", viol, 0);
      chk("rst_mid_rdata", o_cpu_rdata, 8'h00);
      chk("rst_mid_nt_040", nt_mem[12'h040], sh_nt[12'h040]);
      i_rstn  = 1'b1;
      m_addr  = 14'h0;
      m_buf   = 8'h0;
      m_rdata = 8'h0;
      repeat (2) cpu_op(1'b0, 8'h00, 0, 1'b0, 14'h0);

      // Whole-memory comparison against the reference copies
      diffs = 0;
      for (int i = 0; i < 4096; i++) if (nt_mem[i] !== sh_nt[i]) diffs++;
      for (int i = 0; i < 32; i++) if (plt_mem[i] !== sh_plt[i]) diffs++;
      chk("mem_image_diffs", diffs, 0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
